// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop input synchronizer, mid-bit sampling FSM,
// parallel word out with one-cycle valid / framing-error strobes.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | timing half a bit to confirm the start bit
// DATA  | sampling data bits LSB first at each bit-time end
// STOP  | sampling the stop bit
// BRK   | stop bit was low; waiting for the line to return high
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 Clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_s_q, rx_s_d;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_err_q, frame_err_d;

    // Synchronizer flops reset to the idle-line level so reset never looks like a start bit.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rx_meta_d    = rx;
        rx_s_d       = rx_meta_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                end
            end
            START: begin
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BRK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            BRK: begin
                if (rx_s_q) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                clk_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        data_out   = data_out_q;
        data_valid = data_valid_q;
        frame_err  = frame_err_q;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected events,
// a negedge monitor pops and compares on every data_valid / frame_err pulse.
module tb_uart_rx;

    logic       Clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] data_out0;
    logic       data_valid0, frame_err0, busy0;
    logic [4:0] data_out1;
    logic       data_valid1, frame_err1, busy1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_valid0_cyc = 0;
    int last_valid1_cyc = 0;
    logic prev_v0 = 1'b0, prev_e0 = 1'b0, prev_v1 = 1'b0, prev_e1 = 1'b0;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t exp0[$];
    exp_t exp1[$];
    logic [7:0] model0 = 8'h00;

    uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8)) u_dut0 (
        .Clk(Clk), .rst(rst), .rx(rx0),
        .data_out(data_out0), .data_valid(data_valid0),
        .frame_err(frame_err0), .busy(busy0)
    );

    uart_rx #(.CLKS_PER_BIT(4), .DATA_BITS(5)) u_dut1 (
        .Clk(Clk), .rst(rst), .rx(rx1),
        .data_out(data_out1), .data_valid(data_valid1),
        .frame_err(frame_err1), .busy(busy1)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic chk_range(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Monitor: compares each output pulse against the head of the expected queue.
    always @(negedge Clk) begin
        exp_t e;
        if (data_valid0 || frame_err0) begin
            checks++;
            if (exp0.size() == 0) begin
                errors++;
                $display("FAIL dut0 unexpected pulse: valid=%0b ferr=%0b data=%h", data_valid0, frame_err0, data_out0);
            end else begin
                e = exp0.pop_front();
                if (e.err != frame_err0 || data_valid0 == frame_err0 || data_out0 !== e.data) begin
                    errors++;
                    $display("FAIL dut0 event: got valid=%0b ferr=%0b data=%h expected ferr=%0b data=%h",
                             data_valid0, frame_err0, data_out0, e.err, e.data);
                end
            end
            checks++;
            if ((data_valid0 && prev_v0) || (frame_err0 && prev_e0)) begin
                errors++;
                $display("FAIL dut0 pulse width: got >1 cycle expected 1 cycle");
            end
            if (data_valid0) last_valid0_cyc = cyc;
        end
        if (data_valid1 || frame_err1) begin
            checks++;
            if (exp1.size() == 0) begin
                errors++;
                $display("FAIL dut1 unexpected pulse: valid=%0b ferr=%0b data=%h", data_valid1, frame_err1, data_out1);
            end else begin
                e = exp1.pop_front();
                if (e.err != frame_err1 || data_valid1 == frame_err1 || data_out1 !== e.data[4:0]) begin
                    errors++;
                    $display("FAIL dut1 event: got valid=%0b ferr=%0b data=%h expected ferr=%0b data=%h",
                             data_valid1, frame_err1, data_out1, e.err, e.data[4:0]);
                end
            end
            checks++;
            if ((data_valid1 && prev_v1) || (frame_err1 && prev_e1)) begin
                errors++;
                $display("FAIL dut1 pulse width: got >1 cycle expected 1 cycle");
            end
            if (data_valid1) last_valid1_cyc = cyc;
        end
        prev_v0 = data_valid0;
        prev_e0 = frame_err0;
        prev_v1 = data_valid1;
        prev_e1 = frame_err1;
    end

    // Every drive starts and ends 1 time unit after a rising edge.
    task automatic drive(input int sel, input logic v, input int n);
        if (sel == 0) rx0 = v;
        else          rx1 = v;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] data, input logic stop_bit,
                              input int nbits, input int cpb, input int stop_len);
        drive(sel, 1'b0, cpb);
        for (int i = 0; i < nbits; i++) drive(sel, data[i], cpb);
        drive(sel, stop_bit, cpb * stop_len);
    endtask

    task automatic push0(input logic err, input logic [7:0] d);
        exp_t e;
        e.err  = err;
        e.data = d;
        exp0.push_back(e);
    endtask

    initial begin
        int s, v1, v2, busy_cnt;
        exp_t e;

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        chk("reset data_out0", int'(data_out0), 0);
        chk("reset valid0", int'(data_valid0), 0);
        chk("reset ferr0", int'(frame_err0), 0);
        chk("reset busy0", int'(busy0), 0);
        chk("reset busy1", int'(busy1), 0);
        #3 rst = 1'b1;
        @(posedge Clk);
        #1;
        drive(0, 1'b1, 10);

        // 1: 0xA5
        push0(1'b0, 8'hA5);
        model0 = 8'hA5;
        s = cyc;
        send_frame(0, 8'hA5, 1'b1, 8, 16, 1);
        chk_range("A5 latency", last_valid0_cyc - s, 153, 155);
        chk("A5 busy after", int'(busy0), 0);
        chk("A5 data_out", int'(data_out0), 'hA5);
        drive(0, 1'b1, 10);

        // 2: glitch of 4 cycles
        busy_cnt = 0;
        rx0 = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 4) rx0 = 1'b1;
            @(posedge Clk);
            #1;
            if (busy0) busy_cnt++;
        end
        chk_range("glitch busy cycles", busy_cnt, 7, 9);
        chk("glitch data_out", int'(data_out0), 'hA5);
        drive(0, 1'b1, 10);

        // 3: framing error with 3 extra low bit-times
        push0(1'b1, model0);
        send_frame(0, 8'h3C, 1'b0, 8, 16, 4);
        chk("break busy held", int'(busy0), 1);
        drive(0, 1'b1, 6);
        chk("break busy released", int'(busy0), 0);
        chk("ferr data_out kept", int'(data_out0), 'hA5);
        drive(0, 1'b1, 10);

        // 4: back-to-back 0x00 then 0xFF
        push0(1'b0, 8'h00);
        push0(1'b0, 8'hFF);
        send_frame(0, 8'h00, 1'b1, 8, 16, 1);
        v1 = last_valid0_cyc;
        chk("b2b first data", int'(data_out0), 'h00);
        send_frame(0, 8'hFF, 1'b1, 8, 16, 1);
        v2 = last_valid0_cyc;
        chk("b2b spacing", v2 - v1, 160);
        chk("b2b second data", int'(data_out0), 'hFF);
        model0 = 8'hFF;
        drive(0, 1'b1, 10);

        // 5: reset during bit 3 of 0x5A
        drive(0, 1'b0, 16);
        drive(0, 1'b0, 16);
        drive(0, 1'b1, 16);
        drive(0, 1'b0, 16);
        rx0 = 1'b1;
        repeat (8) @(posedge Clk);
        #3 rst = 1'b0;
        #1;
        chk("midreset data_out", int'(data_out0), 0);
        chk("midreset valid", int'(data_valid0), 0);
        chk("midreset ferr", int'(frame_err0), 0);
        chk("midreset busy", int'(busy0), 0);
        model0 = 8'h00;
        repeat (3) @(posedge Clk);
        #3 rst = 1'b1;
        @(posedge Clk);
        #1;
        drive(0, 1'b1, 40);
        chk("post reset idle", int'(busy0), 0);
        push0(1'b0, 8'h81);
        send_frame(0, 8'h81, 1'b1, 8, 16, 1);
        chk("0x81 data_out", int'(data_out0), 'h81);
        drive(0, 1'b1, 10);

        // 6: small config, 0x15
        e.err  = 1'b0;
        e.data = 8'h15;
        exp1.push_back(e);
        s = cyc;
        send_frame(1, 8'h15, 1'b1, 5, 4, 1);
        drive(1, 1'b1, 6);
        chk_range("dut1 latency", last_valid1_cyc - s, 2 + 2 + 6 * 4 - 1, 2 + 2 + 6 * 4 + 1);
        chk("dut1 data_out", int'(data_out1), 'h15);
        chk("dut1 busy after", int'(busy1), 0);

        drive(0, 1'b1, 20);
        chk("dut0 queue drained", exp0.size(), 0);
        chk("dut1 queue drained", exp1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
